// File: rtl/routing_mem_pkg.sv
// routing_mem_pkg: shared view of the routing-table memory.
// Holds the byte-address map of the neighbor tables, the memory geometry and
// the loader state encoding. The sink-list repair block imports this package
// too, so the address map stays in one place.
package routing_mem_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH  = 2048;  // bytes

  localparam logic [15:0] NEIGHBOR_COUNT_ADDR = 16'h068A;
  localparam logic [15:0] NEIGHBOR_ID_BASE    = 16'h0148;
  localparam logic [15:0] NEIGHBOR_ID_STRIDE  = 16'd2;
  localparam logic [15:0] QVALUE_BASE         = 16'h01C8;
  localparam logic [15:0] QVALUE_STRIDE       = 16'd2;
  localparam logic [15:0] SINKID_BASE         = 16'h0248;
  localparam logic [15:0] SINKID_ROW_STRIDE   = 16'd16;
  localparam logic [15:0] SINKID_STRIDE       = 16'd2;
  localparam logic [15:0] SINKID_COUNT_BASE   = 16'h068E;
  localparam logic [15:0] SINKID_COUNT_STRIDE = 16'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_NCNT, ST_WAIT_HDR, ST_SEARCH, ST_ALLOC_ID, ST_NCNT_WR,
    ST_Q_WAIT, ST_Q_WR, ST_SINK_WAIT, ST_SINK_WR, ST_CNT_WR, ST_DRAIN, ST_DONE
  } loader_state_t;

  // Byte address of element idx in a table; wraps modulo 2^16.
  function automatic logic [15:0] slot_addr(input logic [15:0] base,
                                            input logic [15:0] stride,
                                            input logic [15:0] idx);
    return base + stride * idx;
  endfunction

endpackage

// File: rtl/neighbor_table_loader_if.sv
// neighbor_table_loader_if: beacon stream, session control, status and the
// single-port memory bus of the loader.
//   slave  : the loader side (accepts beacons, drives the memory bus)
//   master : the environment side (beacon source, memory, control)
interface neighbor_table_loader_if;
  import routing_mem_pkg::*;

  logic                  start, stop;
  logic                  pkt_valid, pkt_last, pkt_ready;
  logic [WORD_WIDTH-1:0] pkt_data;
  logic [WORD_WIDTH-1:0] address, data_out, data_in;
  logic                  wr_en;
  logic                  overflow, done;

  modport slave (
    input  start, stop, pkt_valid, pkt_data, pkt_last, data_in,
    output pkt_ready, address, wr_en, data_out, overflow, done
  );

  modport master (
    output start, stop, pkt_valid, pkt_data, pkt_last, data_in,
    input  pkt_ready, address, wr_en, data_out, overflow, done
  );
endinterface

// File: rtl/neighbor_id_search.sv
// neighbor_id_search: linear scan of the neighbor ID table.
// A go pulse latches the key and the entry count. Each entry takes three
// cycles: ISSUE (parent registers rd_addr), WAIT (memory captures it),
// CMP (data_in holds the entry). hit/miss are single-cycle strobes; index
// holds the matching slot on hit.
// Ports: clock, nrst (sync, active-low), go, id, count, data_in,
//        rd_addr, index, hit, miss.
module neighbor_id_search
  import routing_mem_pkg::*;
(
  input  logic        clock,
  input  logic        nrst,
  input  logic        go,
  input  logic [15:0] id,
  input  logic [15:0] count,
  input  logic [15:0] data_in,
  output logic [15:0] rd_addr,
  output logic [15:0] index,
  output logic        hit,
  output logic        miss
);
  typedef enum logic [1:0] {P_ISSUE, P_WAIT, P_CMP} phase_t;

  logic        active;
  phase_t      phase;
  logic [15:0] key, limit;

  assign rd_addr = slot_addr(NEIGHBOR_ID_BASE, NEIGHBOR_ID_STRIDE, index);
  // Running off the end of the populated entries is the miss condition.
  assign miss    = active && (phase == P_ISSUE) && (index == limit);
  assign hit     = active && (phase == P_CMP) && (data_in == key);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      active <= 1'b0;
      phase  <= P_ISSUE;
      index  <= '0;
      key    <= '0;
      limit  <= '0;
    end else if (go) begin
      active <= 1'b1;
      phase  <= P_ISSUE;
      index  <= '0;
      key    <= id;
      limit  <= count;
    end else if (active) begin
      case (phase)
        P_ISSUE: if (miss) active <= 1'b0; else phase <= P_WAIT;
        P_WAIT:  phase <= P_CMP;
        default: begin
          if (hit) active <= 1'b0;
          else begin
            index <= index + 16'd1;
            phase <= P_ISSUE;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/neighbor_table_loader.sv
// neighbor_table_loader: writes received neighbor beacons into the shared
// routing-table memory. Each beacon is resolved to a slot (allocating one on
// a miss), then its qValue, sink IDs and sink count are written.
// Ports: clock, nrst (sync, active-low), bus (neighbor_table_loader_if.slave).
// Memory reads are synchronous: address registered in cycle n, data_in valid
// in cycle n+1. All bus outputs are registered.
module neighbor_table_loader
  import routing_mem_pkg::*;
#(
  parameter int MAX_NEIGHBORS = 64,
  parameter int MAX_SINKS     = 8
) (
  input  logic                   clock,
  input  logic                   nrst,
  neighbor_table_loader_if.slave bus
);
  loader_state_t state;
  logic [15:0]   ncnt, nid, slot, k;
  logic          last_word;

  logic          srch_go, srch_hit, srch_miss;
  logic [15:0]   srch_addr, srch_idx;

  // Word0 that is not also the final word starts a lookup.
  assign srch_go = (state == ST_WAIT_HDR) && bus.pkt_valid && !bus.stop && !bus.pkt_last;

  neighbor_id_search u_search (
    .clock   (clock),
    .nrst    (nrst),
    .go      (srch_go),
    .id      (bus.pkt_data),
    .count   (ncnt),
    .data_in (bus.data_in),
    .rd_addr (srch_addr),
    .index   (srch_idx),
    .hit     (srch_hit),
    .miss    (srch_miss)
  );

  // Outputs are set on the transition into a state, so pkt_ready is high for
  // exactly the accepting states and wr_en for exactly the write states.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      bus.address   <= NEIGHBOR_COUNT_ADDR;
      bus.wr_en     <= 1'b0;
      bus.data_out  <= '0;
      bus.pkt_ready <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.done      <= 1'b0;
      ncnt          <= '0;
      nid           <= '0;
      slot          <= '0;
      k             <= '0;
      last_word     <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start) state <= ST_RD_NCNT;
        // The count address has been on the bus since reset, so data_in is valid.
        ST_RD_NCNT: begin
          ncnt          <= bus.data_in;
          state         <= ST_WAIT_HDR;
          bus.pkt_ready <= 1'b1;
        end
        ST_WAIT_HDR: begin
          if (bus.stop) begin
            state         <= ST_DONE;
            bus.done      <= 1'b1;
            bus.pkt_ready <= 1'b0;
          end else if (bus.pkt_valid && !bus.pkt_last) begin
            nid           <= bus.pkt_data;
            state         <= ST_SEARCH;
            bus.pkt_ready <= 1'b0;
          end
        end
        ST_SEARCH: begin
          bus.address <= srch_addr;
          if (srch_hit) begin
            slot          <= srch_idx;
            state         <= ST_Q_WAIT;
            bus.pkt_ready <= 1'b1;
          end else if (srch_miss) begin
            if (ncnt < 16'(MAX_NEIGHBORS)) begin
              slot         <= ncnt;
              state        <= ST_ALLOC_ID;
              bus.address  <= slot_addr(NEIGHBOR_ID_BASE, NEIGHBOR_ID_STRIDE, ncnt);
              bus.data_out <= nid;
              bus.wr_en    <= 1'b1;
            end else begin
              bus.overflow  <= 1'b1;
              state         <= ST_DRAIN;
              bus.pkt_ready <= 1'b1;
            end
          end
        end
        ST_ALLOC_ID: begin
          ncnt         <= ncnt + 16'd1;
          state        <= ST_NCNT_WR;
          bus.address  <= NEIGHBOR_COUNT_ADDR;
          bus.data_out <= ncnt + 16'd1;
          bus.wr_en    <= 1'b1;
        end
        ST_NCNT_WR: begin
          state         <= ST_Q_WAIT;
          bus.pkt_ready <= 1'b1;
        end
        ST_Q_WAIT: if (bus.pkt_valid) begin
          last_word     <= bus.pkt_last;
          k             <= '0;
          state         <= ST_Q_WR;
          bus.pkt_ready <= 1'b0;
          bus.address   <= slot_addr(QVALUE_BASE, QVALUE_STRIDE, slot);
          bus.data_out  <= bus.pkt_data;
          bus.wr_en     <= 1'b1;
        end
        ST_Q_WR: begin
          if (last_word) begin
            state        <= ST_CNT_WR;
            bus.address  <= slot_addr(SINKID_COUNT_BASE, SINKID_COUNT_STRIDE, slot);
            bus.data_out <= '0;
            bus.wr_en    <= 1'b1;
          end else begin
            state         <= ST_SINK_WAIT;
            bus.pkt_ready <= 1'b1;
          end
        end
        // k counts written sinks only, so it saturates at MAX_SINKS and is
        // directly the count to store.
        ST_SINK_WAIT: if (bus.pkt_valid) begin
          last_word     <= bus.pkt_last;
          state         <= ST_SINK_WR;
          bus.pkt_ready <= 1'b0;
          if (k < 16'(MAX_SINKS)) begin
            bus.address  <= slot_addr(slot_addr(SINKID_BASE, SINKID_ROW_STRIDE, slot),
                                      SINKID_STRIDE, k);
            bus.data_out <= bus.pkt_data;
            bus.wr_en    <= 1'b1;
            k            <= k + 16'd1;
          end else begin
            bus.overflow <= 1'b1;
          end
        end
        ST_SINK_WR: begin
          if (last_word) begin
            state        <= ST_CNT_WR;
            bus.address  <= slot_addr(SINKID_COUNT_BASE, SINKID_COUNT_STRIDE, slot);
            bus.data_out <= k;
            bus.wr_en    <= 1'b1;
          end else begin
            state         <= ST_SINK_WAIT;
            bus.pkt_ready <= 1'b1;
          end
        end
        ST_CNT_WR: begin
          state         <= ST_WAIT_HDR;
          bus.pkt_ready <= 1'b1;
        end
        ST_DRAIN: if (bus.pkt_valid && bus.pkt_last) state <= ST_WAIT_HDR;
        ST_DONE:  ;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neighbor_table_loader.sv
module tb_neighbor_table_loader;
  import routing_mem_pkg::*;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  always #5 clock = ~clock;

  neighbor_table_loader_if bus();

  neighbor_table_loader #(.MAX_NEIGHBORS(64), .MAX_SINKS(8)) dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  // Synchronous single-port memory, plus a backdoor preload port.
  logic [15:0] mem [0:MEM_DEPTH/2-1];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0, pl_data = '0;
  int wr_cnt = 0, acc_cnt = 0, clash_cnt = 0;
  int checks = 0, fails = 0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr[10:1]] <= pl_data;
    else if (bus.wr_en) mem[bus.address[10:1]] <= bus.data_out;
    bus.data_in <= mem[bus.address[10:1]];
    if (bus.wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.pkt_valid && bus.pkt_ready) acc_cnt <= acc_cnt + 1;
    if (bus.pkt_ready && bus.wr_en) clash_cnt <= clash_cnt + 1;
  end

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[10:1]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.pkt_ready !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    check(tag, 32'(bus.pkt_ready), 32'd1);
  endtask

  // Caller sits at a negedge. Holds the word until accepted; gap=1 leaves
  // one idle cycle afterwards.
  task automatic send(input logic [15:0] d, input logic l, input bit gap);
    int n = 0;
    bus.pkt_valid = 1'b1; bus.pkt_data = d; bus.pkt_last = l;
    while (bus.pkt_ready !== 1'b1 && n < 400) begin @(negedge clock); n++; end
    if (n >= 400) begin
      checks++; fails++;
      $error("FAIL send_timeout got=%0h expected=accepted", d);
    end
    @(negedge clock);
    bus.pkt_valid = 1'b0; bus.pkt_last = 1'b0;
    if (gap) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_address"},   32'(bus.address),   32'h68A);
    check({pfx, "_wr_en"},     32'(bus.wr_en),     32'd0);
    check({pfx, "_data_out"},  32'(bus.data_out),  32'd0);
    check({pfx, "_pkt_ready"}, 32'(bus.pkt_ready), 32'd0);
    check({pfx, "_overflow"},  32'(bus.overflow),  32'd0);
    check({pfx, "_done"},      32'(bus.done),      32'd0);
  endtask

  int w0, a0;

  initial begin
    bus.start = 0; bus.stop = 0; bus.pkt_valid = 0; bus.pkt_data = '0; bus.pkt_last = 0;
    // ---- session 1: empty table
    @(negedge clock);
    preload(16'h068A, 16'd0);
    @(negedge clock);
    check_reset_vals("rst");
    nrst = 1'b1;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_ready("hdr_ready");

    // A: new neighbor 0x11, two sinks
    w0 = wr_cnt;
    send(16'h0011, 0, 0); send(16'h0005, 0, 0); send(16'h0003, 0, 0); send(16'h0007, 1, 0);
    wait_ready("a_done");
    check("a_id",   32'(rd(16'h148)), 32'h11);
    check("a_ncnt", 32'(rd(16'h68A)), 32'd1);
    check("a_q",    32'(rd(16'h1C8)), 32'd5);
    check("a_s0",   32'(rd(16'h248)), 32'd3);
    check("a_s1",   32'(rd(16'h24A)), 32'd7);
    check("a_cnt",  32'(rd(16'h68E)), 32'd2);
    check("a_nwr",  32'(wr_cnt - w0), 32'd6);
    check("a_ovf",  32'(bus.overflow), 32'd0);

    // B: same ID, row overwritten, stale sink left
    w0 = wr_cnt;
    send(16'h0011, 0, 0); send(16'h0009, 0, 0); send(16'h0004, 1, 0);
    wait_ready("b_done");
    check("b_nwr",   32'(wr_cnt - w0), 32'd3);
    check("b_q",     32'(rd(16'h1C8)), 32'd9);
    check("b_s0",    32'(rd(16'h248)), 32'd4);
    check("b_stale", 32'(rd(16'h24A)), 32'd7);
    check("b_cnt",   32'(rd(16'h68E)), 32'd1);
    check("b_ncnt",  32'(rd(16'h68A)), 32'd1);

    // C: ten sinks, two dropped
    w0 = wr_cnt; a0 = acc_cnt;
    send(16'h0011, 0, 0); send(16'h000C, 0, 0);
    for (int j = 0; j < 10; j++) send(16'h0100 + 16'(j), (j == 9), 0);
    wait_ready("c_done");
    for (int j = 0; j < 8; j++)
      check($sformatf("c_s%0d", j), 32'(rd(16'h248 + 16'(2 * j))), 32'h100 + 32'(j));
    check("c_cnt", 32'(rd(16'h68E)), 32'd8);
    check("c_ovf", 32'(bus.overflow), 32'd1);
    check("c_acc", 32'(acc_cnt - a0), 32'd12);
    check("c_nwr", 32'(wr_cnt - w0), 32'd10);

    // D: new neighbor 0x22 with valid toggling
    w0 = wr_cnt;
    send(16'h0022, 0, 1); send(16'h000A, 0, 1); send(16'h0055, 1, 1);
    wait_ready("d_done");
    check("d_id",    32'(rd(16'h14A)), 32'h22);
    check("d_ncnt",  32'(rd(16'h68A)), 32'd2);
    check("d_q",     32'(rd(16'h1CA)), 32'hA);
    check("d_s0",    32'(rd(16'h258)), 32'h55);
    check("d_cnt",   32'(rd(16'h690)), 32'd1);
    check("d_nwr",   32'(wr_cnt - w0), 32'd5);
    check("d_clash", 32'(clash_cnt),   32'd0);

    // E: last on word1 -> qValue then zero count
    w0 = wr_cnt;
    send(16'h0022, 0, 0); send(16'h000B, 1, 0);
    wait_ready("e_done");
    check("e_q",   32'(rd(16'h1CA)), 32'hB);
    check("e_cnt", 32'(rd(16'h690)), 32'd0);
    check("e_nwr", 32'(wr_cnt - w0), 32'd2);

    // F: last on word0 -> nothing written
    w0 = wr_cnt;
    send(16'h0033, 1, 0);
    wait_ready("f_done");
    repeat (3) @(negedge clock);
    check("f_nwr",  32'(wr_cnt - w0), 32'd0);
    check("f_ncnt", 32'(rd(16'h68A)), 32'd2);

    // stop in WAIT_HDR
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    check("stop_done",  32'(bus.done),      32'd1);
    check("stop_ready", 32'(bus.pkt_ready), 32'd0);

    // ---- session 2: full table
    nrst = 1'b0;
    preload(16'h068A, 16'd64);
    for (int i = 0; i < 64; i++) preload(16'h148 + 16'(2 * i), 16'h1000 + 16'(i));
    @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_ready("hdr_ready2");

    // G: unknown ID with table full -> drained
    w0 = wr_cnt; a0 = acc_cnt;
    send(16'h0099, 0, 0); send(16'h0001, 0, 0); send(16'h0002, 0, 0); send(16'h0003, 1, 0);
    wait_ready("g_done");
    check("g_nwr",  32'(wr_cnt - w0),  32'd0);
    check("g_acc",  32'(acc_cnt - a0), 32'd4);
    check("g_ovf",  32'(bus.overflow), 32'd1);
    check("g_ncnt", 32'(rd(16'h68A)),  32'd64);

    // H: reset in the middle of a beacon, during the qValue write
    send(16'h1000, 0, 0); send(16'h0077, 0, 0);
    check("h_wr_en", 32'(bus.wr_en),    32'd1);
    check("h_addr",  32'(bus.address),  32'h1C8);
    check("h_data",  32'(bus.data_out), 32'h77);
    nrst = 1'b0;
    @(negedge clock);
    check_reset_vals("abort");
    nrst = 1'b1;
    repeat (2) @(negedge clock);
    check("final_clash", 32'(clash_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
